muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the multicycle MIPS datapath.
- Extends the funct decode with the HI/LO group: mult, multu, div, divu, mthi, mtlo.
- Computes one result bit per clock and holds results in internal HI/LO registers.
- The multicycle controller starts an operation, waits on busy/done, then reads hi/lo for mfhi/mflo.

---
 rtl/muldiv_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the HI/LO register pair
// for the multicycle MIPS datapath.
//
// One result bit is produced per clock. An operation accepted at edge E0 writes
// hi/lo and pulses done at edge E0+WIDTH+1; busy is high for WIDTH+1 cycles.
// mthi/mtlo write hi/lo directly on the start edge.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   request, sampled only while idle
//   funct  in   6-bit R-type funct qualifying start
//   a      in   rs operand (multiplicand / dividend / mthi-mtlo data)
//   b      in   rt operand (multiplier / divisor)
//   busy   out  operation in progress, start ignored
//   done   out  one-cycle pulse when hi/lo were just written by mult/div
//   hi     out  HI register (product upper half / remainder)
//   lo     out  LO register (product lower half / quotient)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's complement negate when neg is set (magnitude / sign restore).
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [CNTW-1:0]    cnt_r;
    logic [WIDTH:0]     acc_r;      // partial product upper half / partial remainder
    logic [WIDTH-1:0]   mq_r;       // multiplier shifting out, or dividend out / quotient in
    logic [WIDTH-1:0]   opb_r;      // multiplicand magnitude or divisor magnitude
    logic               is_div_r;
    logic               neg_r;      // sign_a ^ sign_b
    logic               sign_a_r;
    logic               dz_r;       // divide by zero
    logic               busy_r, done_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               iter_op_s, signed_s, sa_s, sb_s;
    logic               load_s, step_s, fix_s, wr_hi_s, wr_lo_s;
    logic               busy_nxt_s, done_nxt_s;
    logic [WIDTH:0]     mul_sum_s, mul_sel_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic               div_ok_s;
    logic [2*WIDTH-1:0] prod_raw_s, prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;

    // mult/multu/div/divu share 0110xx; bit1 selects divide, bit0 selects unsigned.
    assign iter_op_s = (funct[5:2] == 4'b0110);
    assign signed_s  = ~funct[0];
    assign sa_s      = signed_s & a[WIDTH-1];
    assign sb_s      = signed_s & b[WIDTH-1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && iter_op_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNTW'(1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        load_s  = 1'b0;
        step_s  = 1'b0;
        fix_s   = 1'b0;
        wr_hi_s = 1'b0;
        wr_lo_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s  = iter_op_s;
                    wr_hi_s = (funct == F_MTHI);
                    wr_lo_s = (funct == F_MTLO);
                end else begin
                    load_s  = 1'b0;
                end
            end
            ST_RUN:  step_s = 1'b1;
            ST_FIX:  fix_s  = 1'b1;
            default: load_s = 1'b0;
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = fix_s;
    end

    // One iteration step for each operation, plus final sign correction.
    always_comb begin
        // Shift-add multiply: conditionally add multiplicand, then shift {acc,mq} right.
        mul_sum_s   = acc_r + {1'b0, opb_r};
        mul_sel_s   = mq_r[0] ? mul_sum_s : acc_r;
        // Restoring divide: shift next dividend bit in, keep the difference if no borrow.
        div_shift_s = {acc_r[WIDTH-1:0], mq_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opb_r};
        div_ok_s    = ~div_diff_s[WIDTH+1];

        prod_raw_s  = {acc_r[WIDTH-1:0], mq_r};
        if (neg_r) begin
            prod_fix_s = -prod_raw_s;
        end else begin
            prod_fix_s = prod_raw_s;
        end
        // With a zero divisor the remainder path ends holding |a|, so restoring the
        // sign of a yields the original a; only the quotient needs overriding.
        if (dz_r) begin
            quot_fix_s = {WIDTH{1'b1}};
        end else begin
            quot_fix_s = cond_neg(mq_r, neg_r);
        end
        rem_fix_s = cond_neg(acc_r[WIDTH-1:0], sign_a_r);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= {CNTW{1'b0}};
            acc_r    <= {(WIDTH+1){1'b0}};
            mq_r     <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_r    <= 1'b0;
            sign_a_r <= 1'b0;
            dz_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (load_s) begin
                cnt_r    <= CNTW'(WIDTH);
                acc_r    <= {(WIDTH+1){1'b0}};
                is_div_r <= funct[1];
                neg_r    <= sa_s ^ sb_s;
                sign_a_r <= sa_s;
                dz_r     <= funct[1] && (b == {WIDTH{1'b0}});
                if (funct[1]) begin
                    mq_r  <= cond_neg(a, sa_s);
                    opb_r <= cond_neg(b, sb_s);
                end else begin
                    mq_r  <= cond_neg(b, sb_s);
                    opb_r <= cond_neg(a, sa_s);
                end
            end else if (step_s) begin
                cnt_r <= cnt_r - CNTW'(1);
                if (is_div_r) begin
                    acc_r <= div_ok_s ? div_diff_s[WIDTH:0] : div_shift_s;
                    mq_r  <= {mq_r[WIDTH-2:0], div_ok_s};
                end else begin
                    acc_r <= {1'b0, mul_sel_s[WIDTH:1]};
                    mq_r  <= {mul_sel_s[0], mq_r[WIDTH-1:1]};
                end
            end else begin
                cnt_r <= cnt_r;
            end

            if (fix_s) begin
                if (is_div_r) begin
                    hi_r <= rem_fix_s;
                    lo_r <= quot_fix_s;
                end else begin
                    hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_r <= prod_fix_s[WIDTH-1:0];
                end
            end else begin
                if (wr_hi_s) begin
                    hi_r <= a;
                end else begin
                    hi_r <= hi_r;
                end
                if (wr_lo_s) begin
                    lo_r <= a;
                end else begin
                    lo_r <= lo_r;
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a WIDTH=32 instance and a WIDTH=8 instance.
module tb_muldiv_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, busy, done;
    logic [5:0]  funct;
    logic [31:0] a, b, hi, lo;
    logic        start8, busy8, done8;
    logic [5:0]  funct8;
    logic [7:0]  a8, b8, hi8, lo8;

    int n_pass = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .funct(funct8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    // Reference model for the 32-bit unit: {hi, lo}.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, ua, ub;
        logic [63:0] r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = longint'({32'h0, av});
        ub = longint'({32'h0, bv});
        case (f)
            F_MULT:  r = 64'(sa * sb);
            F_MULTU: r = 64'(ua * ub);
            F_DIV:   r = (bv == 32'h0) ? {av, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            F_DIVU:  r = (bv == 32'h0) ? {av, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    // Issue one iterative op and wait (bounded) for done; lat=0 means timeout.
    task automatic run_op(input bit w8, input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] ohi, output logic [31:0] olo, output int lat, output int bcnt);
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; funct8 = f; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start = 1'b1; funct = f; a = av; b = bv;
        end
        @(posedge clk); #1;
        start = 1'b0; start8 = 1'b0;
        a = $urandom; b = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        funct = 6'($urandom); funct8 = 6'($urandom);
        bcnt = ((w8 ? busy8 : busy) === 1'b1) ? 1 : 0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if ((w8 ? done8 : done) === 1'b1) begin
                lat = i;
                break;
            end
            if ((w8 ? busy8 : busy) === 1'b1) bcnt++;
        end
        ohi = w8 ? {24'h0, hi8} : hi;
        olo = w8 ? {24'h0, lo8} : lo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %h want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %h want 0", done); else n_pass++;
        n_total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
        n_total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk); start = 1'b1; funct = F_MTHI; a = 32'hA5A5_A5A5;
        @(posedge clk); #1; start = 1'b0;
        n_total++; if (hi !== 32'hA5A5_A5A5) $display("FAIL mthi_hi got %h want a5a5a5a5", hi); else n_pass++;
        n_total++; if (lo !== 32'h0) $display("FAIL mthi_lo got %h want 0", lo); else n_pass++;
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL mthi_busy_done got %b want 00", {busy, done}); else n_pass++;
        @(negedge clk); start = 1'b1; funct = F_MTLO; a = 32'h3C3C_1234;
        @(posedge clk); #1; start = 1'b0;
        n_total++; if (lo !== 32'h3C3C_1234) $display("FAIL mtlo_lo got %h want 3c3c1234", lo); else n_pass++;
        n_total++; if (hi !== 32'hA5A5_A5A5) $display("FAIL mtlo_hi got %h want a5a5a5a5", hi); else n_pass++;
        @(negedge clk); start = 1'b1; funct = F_ADD; a = 32'hDEAD_BEEF; b = 32'h1;
        @(posedge clk); #1; start = 1'b0;
        n_total++; if ({hi, lo} !== 64'hA5A5_A5A5_3C3C_1234) $display("FAIL other_funct_hilo got %h want a5a5a5a53c3c1234", {hi, lo}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL other_funct_busy got %h want 0", busy); else n_pass++;
    endtask

    task automatic test_mult();
        logic [31:0] ohi, olo;
        logic [63:0] e;
        int lat, bcnt;
        exp_q.push_back(64'hFFFF_FFFE_0000_0001);
        run_op(1'b0, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL multu_max got %h want %h", {ohi, olo}, e); else n_pass++;
        n_total++; if (lat !== 33) $display("FAIL multu_latency got %0d want 33", lat); else n_pass++;
        n_total++; if (bcnt !== 33) $display("FAIL multu_busy_cycles got %0d want 33", bcnt); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL done_pulse_width got %b want 00", {busy, done}); else n_pass++;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFD6);
        run_op(1'b0, F_MULT, 32'hFFFF_FFF9, 32'd6, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL mult_neg got %h want %h", {ohi, olo}, e); else n_pass++;
    endtask

    task automatic test_div();
        logic [31:0] ohi, olo;
        logic [63:0] e;
        int lat, bcnt;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b0, F_DIV, 32'hFFFF_FFF9, 32'd2, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL div_neg got %h want %h", {ohi, olo}, e); else n_pass++;
        exp_q.push_back({32'd2, 32'd14});
        run_op(1'b0, F_DIVU, 32'd100, 32'd7, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL divu_basic got %h want %h", {ohi, olo}, e); else n_pass++;
        exp_q.push_back(64'h0000_1234_FFFF_FFFF);
        run_op(1'b0, F_DIVU, 32'h1234, 32'h0, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL divu_by_zero got %h want %h", {ohi, olo}, e); else n_pass++;
        n_total++; if (lat !== 33) $display("FAIL div_by_zero_latency got %0d want 33", lat); else n_pass++;
        exp_q.push_back(64'hFFFF_FFF9_FFFF_FFFF);
        run_op(1'b0, F_DIV, 32'hFFFF_FFF9, 32'h0, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL div_neg_by_zero got %h want %h", {ohi, olo}, e); else n_pass++;
        exp_q.push_back(64'h0000_0000_8000_0000);
        run_op(1'b0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL div_overflow got %h want %h", {ohi, olo}, e); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ohi, olo, av, bv;
        logic [5:0]  f;
        logic [63:0] e;
        int lat, bcnt;
        for (int i = 0; i < 12; i++) begin
            f  = {4'b0110, 2'($urandom_range(0, 3))};
            av = $urandom;
            case (i % 4)
                0:       bv = 32'h0;
                1:       bv = 32'($urandom_range(1, 15));
                2:       bv = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: bv = $urandom;
            endcase
            exp_q.push_back(model(f, av, bv));
            run_op(1'b0, f, av, bv, ohi, olo, lat, bcnt);
            e = exp_q.pop_front();
            n_total++;
            if ({ohi, olo} !== e || lat !== 33)
                $display("FAIL random_%0d funct=%b a=%h b=%h got %h lat %0d want %h lat 33", i, f, av, bv, {ohi, olo}, lat, e);
            else n_pass++;
        end
    endtask

    task automatic test_busy_ignore();
        logic [63:0] e;
        int lat;
        bit seen;
        exp_q.push_back({32'd0, 32'd15});
        @(negedge clk); start = 1'b1; funct = F_MULTU; a = 32'd3; b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); start = 1'b1; funct = F_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        for (int i = 7; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        e = exp_q.pop_front();
        n_total++; if ({hi, lo} !== e) $display("FAIL busy_ignore_result got %h want %h", {hi, lo}, e); else n_pass++;
        n_total++; if (lat !== 33) $display("FAIL busy_ignore_latency got %0d want 33", lat); else n_pass++;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy === 1'b1) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL busy_ignore_no_queue got busy %b want 0", seen); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ohi, olo;
        logic [63:0] e;
        int lat, bcnt;
        exp_q.push_back(model(F_MULT, 32'h0001_0000, 32'hFFFF_0000));
        run_op(1'b0, F_MULT, 32'h0001_0000, 32'hFFFF_0000, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL b2b_first got %h want %h", {ohi, olo}, e); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL b2b_done_cycle got %h want 1", done); else n_pass++;
        exp_q.push_back({32'd5, 32'd12});
        run_op(1'b0, F_DIVU, 32'd1001, 32'd83, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL b2b_second got %h want %h", {ohi, olo}, e); else n_pass++;
        n_total++; if (lat !== 33) $display("FAIL b2b_second_latency got %0d want 33", lat); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk); start = 1'b1; funct = F_MTHI; a = 32'h1111_2222;
        @(negedge clk); funct = F_MTLO; a = 32'h3333_4444;
        @(negedge clk); funct = F_MULTU; a = 32'hFFFF_FFFF; b = 32'h7;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL mid_reset_busy_done got %b want 00", {busy, done}); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h0) $display("FAIL mid_reset_hilo got %h want 0", {hi, lo}); else n_pass++;
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL mid_reset_no_done got %b want 0", seen); else n_pass++;
    endtask

    task automatic test_width8();
        logic [31:0] ohi, olo;
        logic [63:0] e;
        int lat, bcnt;
        exp_q.push_back({32'h0000_00FE, 32'h0000_0001});
        run_op(1'b1, F_MULTU, 32'hFF, 32'hFF, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL w8_multu got %h want %h", {ohi, olo}, e); else n_pass++;
        n_total++; if (lat !== 9) $display("FAIL w8_latency got %0d want 9", lat); else n_pass++;
        n_total++; if (bcnt !== 9) $display("FAIL w8_busy_cycles got %0d want 9", bcnt); else n_pass++;
        exp_q.push_back({32'h0000_00FF, 32'h0000_00FD});
        run_op(1'b1, F_DIV, 32'hF9, 32'h02, ohi, olo, lat, bcnt);
        e = exp_q.pop_front();
        n_total++; if ({ohi, olo} !== e) $display("FAIL w8_div got %h want %h", {ohi, olo}, e); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; funct = 6'h0; a = 32'h0; b = 32'h0;
        start8 = 1'b0; funct8 = 6'h0; a8 = 8'h0; b8 = 8'h0;
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
